// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 dual-colour LED matrix scan controller.
package matrix_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned ROW_W = $clog2(ROWS);

    typedef struct packed {
        logic [COLS-1:0] r;
        logic [COLS-1:0] g;
    } pix_row_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Active-low one-cold row select for row n.
    function automatic logic [ROWS-1:0] row_sel(input logic [ROW_W-1:0] n);
        return ~(ROWS'(1) << n);
    endfunction

endpackage

// File: rtl/matrix_frame_buf.sv
// Double-buffered frame store: writes go to the back buffer, reads come from the
// front buffer, and a swap flips the buffer-select pointer.
module matrix_frame_buf
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  pix_row_t         wr_data_i,
    input  logic [ROW_W-1:0] rd_row_i,
    input  logic             swap_i,
    output pix_row_t         rd_data_c
);

    pix_row_t mem_q [2][ROWS];
    logic     sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            if (wr_en_i) begin
                mem_q[~sel_q][wr_row_i] <= wr_data_i;
            end
            if (swap_i) begin
                sel_q <= ~sel_q;
            end
        end
    end

    assign rd_data_c = mem_q[sel_q][rd_row_i];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed scan controller for the 8x8 red/green LED matrix with tear-free
// buffer swaps. Optional per-row dimming is enabled by defining MATRIX_SCAN_DIM_EN.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned DIV   = 2000,
    parameter int unsigned BLANK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
`ifdef MATRIX_SCAN_DIM_EN
    input  logic [2:0]       bright,
`endif
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_r,
    input  logic [COLS-1:0]  wr_g,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             frame_tick,
    output logic [COLS-1:0]  led_r,
    output logic [COLS-1:0]  led_g,
    output logic [ROWS-1:0]  row
);

    localparam int unsigned DWELL_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CNT_W     = $clog2(DWELL_MAX);
    localparam int unsigned THR_W     = CNT_W + 1;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [ROW_W-1:0] row_idx_q,  row_idx_d;
    logic [ROWS-1:0]  row_q,      row_d;
    pix_row_t         leds_q,     leds_d;
    logic [THR_W-1:0] thr_q,      thr_d;
    logic             pending_q,  pending_d;
    logic             wr_ready_q, wr_ready_d;
    logic             swap_ack_q, swap_ack_d;
    logic             tick_q,     tick_d;

    logic             swap_now_c;
    logic             wr_en_c;
    logic [31:0]      on_c;
    logic [THR_W-1:0] thr_c;
    pix_row_t         wr_pix_c;
    pix_row_t         front_c;

    // Number of lit SHOW cycles; columns go dark once the countdown drops below thr.
`ifdef MATRIX_SCAN_DIM_EN
    assign on_c = ((32'(bright) + 32'd1) * DIV) >> 3;
`else
    assign on_c = DIV;
`endif
    assign thr_c = THR_W'(DIV - on_c);

    assign wr_en_c    = wr_valid && wr_ready_q;
    assign wr_pix_c   = '{r: wr_r, g: wr_g};
    assign swap_now_c = pending_q && (tick_q || (state_q == ST_IDLE));

    matrix_frame_buf u_frame_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_c),
        .wr_row_i  (wr_row),
        .wr_data_i (wr_pix_c),
        .rd_row_i  (row_idx_q),
        .swap_i    (swap_now_c),
        .rd_data_c (front_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_idx_d  = row_idx_q;
        row_d      = row_q;
        leds_d     = leds_q;
        thr_d      = thr_q;
        pending_d  = pending_q;
        wr_ready_d = wr_ready_q;
        swap_ack_d = 1'b0;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            row_idx_d = '0;
            row_d     = '1;
            leds_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_BLANK;
                    cnt_d     = CNT_W'(BLANK - 1);
                    row_idx_d = '0;
                    row_d     = '1;
                    leds_d    = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = CNT_W'(DIV - 1);
                        row_d   = row_sel(row_idx_q);
                        thr_d   = thr_c;
                        leds_d  = ({1'b0, cnt_d} >= thr_d) ? front_c : '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_BLANK;
                        cnt_d     = CNT_W'(BLANK - 1);
                        row_idx_d = row_idx_q + ROW_W'(1);
                        row_d     = '1;
                        leds_d    = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if ({1'b0, cnt_d} < thr_q) begin
                            leds_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    row_d   = '1;
                    leds_d  = '0;
                end
            endcase
        end

        tick_d = (state_d == ST_SHOW) && (row_idx_d == ROW_W'(ROWS - 1)) && (cnt_d == '0);

        // A swap re-opens the write port; a new request is only taken while it is open.
        if (swap_now_c) begin
            pending_d  = 1'b0;
            wr_ready_d = 1'b1;
            swap_ack_d = 1'b1;
        end else if (swap_req && wr_ready_q) begin
            pending_d  = 1'b1;
            wr_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            row_idx_q  <= '0;
            row_q      <= '1;
            leds_q     <= '0;
            thr_q      <= '0;
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            swap_ack_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
            leds_q     <= leds_d;
            thr_q      <= thr_d;
            pending_q  <= pending_d;
            wr_ready_q <= wr_ready_d;
            swap_ack_q <= swap_ack_d;
            tick_q     <= tick_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign swap_ack   = swap_ack_q;
    assign frame_tick = tick_q;
    assign led_r      = leds_q.r;
    assign led_g      = leds_q.g;
    assign row        = row_q;

endmodule
